match_accum_pipe: RTL

- Parametrised successor to the single-variant match counter.
- Consumes a stream of tagged commands (enum tag + payload + channel id) over a valid/ready handshake.
- Matches on the tag, updates one of CHANNELS per-channel accumulators, and emits the new accumulator value through a registered, back-pressurable output stage.
- Sits in the output_test match suite as the multi-channel, stateful match DUT.

---
 rtl/match_pkg.sv | 14 +
 rtl/match_accum_pipe_if.sv | 27 ++
 rtl/match_accum_alu.sv | 53 +++++
 rtl/match_accum_pipe.sv | 96 +++++++++
 4 files changed

// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared tag constants and default widths for the match accumulator
package match_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_TAG_W    = 8;

    localparam int TAG_CLEAR = 0;
    localparam int TAG_ADD   = 1;
    localparam int TAG_SET   = 2;
    localparam int TAG_HOLD  = 3;
    localparam int TAG_ADD2  = 4;

endpackage

// File: rtl/match_accum_pipe_if.sv
// rtl/match_accum_pipe_if.sv - command/result handshake bundle for match_accum_pipe
interface match_accum_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CH_W  = 2,
    parameter int TAG_W = 8
);
    logic             _i_valid;
    logic             _o_ready;
    logic [TAG_W-1:0] _i_tag;
    logic [WIDTH-1:0] _i_payload;
    logic [CH_W-1:0]  _i_chan;
    logic             _o_valid;
    logic             _i_ready;
    logic [WIDTH-1:0] __output;
    logic [CH_W-1:0]  _o_chan;
    logic             _o_err;

    modport master (
        output _i_valid, _i_tag, _i_payload, _i_chan, _i_ready,
        input  _o_ready, _o_valid, __output, _o_chan, _o_err
    );

    modport slave (
        input  _i_valid, _i_tag, _i_payload, _i_chan, _i_ready,
        output _o_ready, _o_valid, __output, _o_chan, _o_err
    );
endinterface

// File: rtl/match_accum_alu.sv
// rtl/match_accum_alu.sv - combinational tag decode and accumulator update
module match_accum_alu
    import match_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic [TAG_W-1:0] tag,
    input  logic [WIDTH-1:0] payload,
    input  logic [WIDTH-1:0] acc,
    input  logic             chan_ok,
    output logic [WIDTH-1:0] next_acc,
    output logic             write_en,
    output logic             err
);

    always_comb begin
        next_acc = acc;
        write_en = 1'b0;
        err      = 1'b0;
        // An out-of-range channel overrides the tag entirely.
        if (!chan_ok) begin
            next_acc = '0;
            err      = 1'b1;
        end else begin
            case (tag)
                TAG_W'(TAG_CLEAR): begin
                    next_acc = '0;
                    write_en = 1'b1;
                end
                TAG_W'(TAG_ADD): begin
                    next_acc = acc + payload;
                    write_en = 1'b1;
                end
                TAG_W'(TAG_SET): begin
                    next_acc = payload;
                    write_en = 1'b1;
                end
                TAG_W'(TAG_HOLD): begin
                    next_acc = acc;
                end
                TAG_W'(TAG_ADD2): begin
                    next_acc = acc + WIDTH'(2);
                    write_en = 1'b1;
                end
                default: begin
                    err = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/match_accum_pipe.sv
// rtl/match_accum_pipe.sv - multi-channel tagged accumulator with registered back-pressurable result
module match_accum_pipe
    import match_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int TAG_W    = DEF_TAG_W
) (
    input  logic         _i_clk,
    input  logic         _i_rst_n,
    match_accum_pipe_if.slave bus
);

    logic [WIDTH-1:0] acc_q [CHANNELS];
    logic [WIDTH-1:0] acc_sel;
    logic [WIDTH-1:0] next_acc;
    logic             write_en;
    logic             alu_err;
    logic             chan_ok;
    logic             accept;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]  out_chan_q;
    logic             out_err_q;

    assign bus._o_ready = !out_valid_q || bus._i_ready;
    assign accept       = bus._i_valid && bus._o_ready;
    assign chan_ok      = (32'(bus._i_chan) < CHANNELS);

    // Mux by compare so a channel id past CHANNELS never indexes the array.
    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus._i_chan == CH_W'(i)) begin
                acc_sel = acc_q[i];
            end
        end
    end

    match_accum_alu #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_alu (
        .tag      (bus._i_tag),
        .payload  (bus._i_payload),
        .acc      (acc_sel),
        .chan_ok  (chan_ok),
        .next_acc (next_acc),
        .write_en (write_en),
        .err      (alu_err)
    );

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept && write_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus._i_chan == CH_W'(i)) begin
                    acc_q[i] <= next_acc;
                end
            end
        end
    end

    always_ff @(posedge _i_clk or negedge _i_rst_n) begin
        if (!_i_rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= next_acc;
            out_chan_q  <= bus._i_chan;
            out_err_q   <= alu_err;
        end else if (bus._i_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus._o_valid = out_valid_q;
    assign bus.__output = out_data_q;
    assign bus._o_chan  = out_chan_q;
    assign bus._o_err   = out_err_q;

    a_stall_stable: assert property (@(posedge _i_clk) disable iff (!_i_rst_n)
        (out_valid_q && !bus._i_ready) |=> $stable({out_data_q, out_chan_q, out_err_q}));

    a_no_x: assert property (@(posedge _i_clk) disable iff (!_i_rst_n)
        !$isunknown({bus._o_ready, out_valid_q, out_data_q, out_chan_q, out_err_q}));

endmodule
